// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencing controller:
// operation encodings, controller states and HI/LO result packing.
package muldiv_defs;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_code_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    // HI/LO write word layout: LO in the upper half, HI in the lower half.
    localparam int HL_LO_MSB = 63;
    localparam int HL_LO_LSB = 32;
    localparam int HL_HI_MSB = 31;
    localparam int HL_HI_LSB = 0;

    // LO value written for a divide by zero (HI gets the dividend).
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    function automatic logic op_is_div(input op_code_t op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input op_code_t op);
        return ~op[0];
    endfunction

    function automatic logic [63:0] pack_hl(input logic [31:0] lo, input logic [31:0] hi);
        logic [63:0] v;
        v = '0;
        v[HL_LO_MSB:HL_LO_LSB] = lo;
        v[HL_HI_MSB:HL_HI_LSB] = hi;
        return v;
    endfunction

    // Both units return {upper,lower} = {hi,lo} or {remainder,quotient};
    // the lower half goes to LO and the upper half to HI.
    function automatic logic [63:0] unit_to_hl(input logic [63:0] pair);
        return pack_hl(pair[31:0], pair[63:32]);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Bundle of the EX-side handshake and the mul/div unit connections.
// slave is the controller's view, master the pipeline/units side.
interface muldiv_ctrl_if;
    import muldiv_defs::*;

    logic        op_valid;
    op_code_t    op_code;
    logic [31:0] op_src1;
    logic [31:0] op_src2;
    logic        flush;
    logic        ex_advance;

    logic        mul_signed;
    logic [31:0] mul_ina;
    logic [31:0] mul_inb;
    logic [63:0] mul_result;

    logic        div_start;
    logic        div_signed;
    logic [31:0] div_opdata1;
    logic [31:0] div_opdata2;
    logic        div_annul;
    logic [63:0] div_result;
    logic        div_ready;

    logic        stallreq;
    logic        hl_we;
    logic [63:0] hl_wdata;
    logic        busy;
    logic        timeout_err;

    modport slave (
        input  op_valid, op_code, op_src1, op_src2, flush, ex_advance,
        input  mul_result, div_result, div_ready,
        output mul_signed, mul_ina, mul_inb,
        output div_start, div_signed, div_opdata1, div_opdata2, div_annul,
        output stallreq, hl_we, hl_wdata, busy, timeout_err
    );

    modport master (
        output op_valid, op_code, op_src1, op_src2, flush, ex_advance,
        output mul_result, div_result, div_ready,
        input  mul_signed, mul_ina, mul_inb,
        input  div_start, div_signed, div_opdata1, div_opdata2, div_annul,
        input  stallreq, hl_we, hl_wdata, busy, timeout_err
    );

endinterface

// File: rtl/muldiv_ctrl.sv
// Sequencing controller for the EX-stage multiplier and divider. Accepts one
// mul/div op, stalls EX while it is in flight, then holds the HI/LO write
// until EX advances. Handles flush, divide-by-zero and a divider watchdog.
module muldiv_ctrl
    import muldiv_defs::*;
#(
    parameter int MUL_LAT     = 2,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          resetn,
    muldiv_ctrl_if.slave  bus
);

    localparam int             WD_W     = $clog2(DIV_TIMEOUT);
    localparam logic [2:0]     CNT_INIT = 3'(MUL_LAT - 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(DIV_TIMEOUT - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [2:0]      r_cnt;
    logic [WD_W-1:0] r_wd;
    logic            r_signed;
    logic [31:0]     r_src1;
    logic [31:0]     r_src2;
    logic [63:0]     r_result;

    logic            w_accept;
    logic            w_div0;
    logic            w_wd_last;
    logic            w_in_mul;
    logic            w_in_div;
    logic            w_hl_we;

    assign w_in_mul  = (r_state == S_MUL);
    assign w_in_div  = (r_state == S_DIV);
    assign w_wd_last = (r_wd == WD_LAST);
    assign w_div0    = op_is_div(bus.op_code) && (bus.op_src2 == '0);

    // Next-state decision; flush overrides every in-flight state.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.op_valid && !bus.flush) begin
                    w_accept = 1'b1;
                    if (!op_is_div(bus.op_code)) begin
                        w_state_next = S_MUL;
                    end else if (w_div0) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_DIV;
                    end
                end
            end
            S_MUL: begin
                if (bus.flush) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DIV: begin
                if (bus.flush) begin
                    w_state_next = S_IDLE;
                end else if (bus.div_ready || w_wd_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.flush || bus.ex_advance) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand latch, latency counter, watchdog and result capture.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt    <= '0;
            r_wd     <= '0;
            r_signed <= 1'b0;
            r_src1   <= '0;
            r_src2   <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_signed <= op_is_signed(bus.op_code);
                        r_src1   <= bus.op_src1;
                        r_src2   <= bus.op_src2;
                        r_cnt    <= CNT_INIT;
                        r_wd     <= '0;
                        if (w_div0) begin
                            r_result <= pack_hl(DIV0_LO, bus.op_src1);
                        end
                    end
                end
                S_MUL: begin
                    if (!bus.flush) begin
                        if (r_cnt == '0) begin
                            r_result <= unit_to_hl(bus.mul_result);
                        end else begin
                            r_cnt <= r_cnt - 3'd1;
                        end
                    end
                end
                S_DIV: begin
                    if (!bus.flush) begin
                        r_wd <= r_wd + WD_W'(1);
                        if (bus.div_ready) begin
                            r_result <= unit_to_hl(bus.div_result);
                        end else if (w_wd_last) begin
                            r_result <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign w_hl_we = (r_state == S_DONE) && !bus.flush;

    assign bus.stallreq    = !bus.flush &&
                             (((r_state == S_IDLE) && bus.op_valid) || w_in_mul || w_in_div);
    assign bus.mul_signed  = w_in_mul && r_signed;
    assign bus.mul_ina     = w_in_mul ? r_src1 : '0;
    assign bus.mul_inb     = w_in_mul ? r_src2 : '0;
    assign bus.div_start   = w_in_div;
    assign bus.div_signed  = w_in_div && r_signed;
    assign bus.div_opdata1 = w_in_div ? r_src1 : '0;
    assign bus.div_opdata2 = w_in_div ? r_src2 : '0;
    assign bus.div_annul   = w_in_div && (bus.flush || (!bus.div_ready && w_wd_last));
    assign bus.timeout_err = w_in_div && !bus.flush && !bus.div_ready && w_wd_last;
    assign bus.hl_we       = w_hl_we;
    assign bus.hl_wdata    = w_hl_we ? r_result : '0;
    assign bus.busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: a table of single operations run to
// completion, plus hand-written flush, watchdog, DONE-hold and reset sequences.
module tb_muldiv_ctrl;
    import muldiv_defs::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   testsRun = 0;
    int   testsFailed = 0;

    always #5 clk = ~clk;

    muldiv_ctrl_if bus();

    muldiv_ctrl #(.MUL_LAT(2), .DIV_TIMEOUT(64)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Multiplier model: combinational product of the presented operands.
    assign bus.mul_result = bus.mul_signed ?
        ({{32{bus.mul_ina[31]}}, bus.mul_ina} * {{32{bus.mul_inb[31]}}, bus.mul_inb}) :
        ({32'd0, bus.mul_ina} * {32'd0, bus.mul_inb});

    // Divider model: ready pulse on the divReadyAt-th start cycle (0 = never).
    int          divReadyAt = 0;
    logic [63:0] divRes = '0;
    int          divCnt = 0;

    always_ff @(posedge clk) begin
        if (!bus.div_start || bus.div_annul) divCnt <= 0;
        else                                 divCnt <= divCnt + 1;
    end

    assign bus.div_ready  = bus.div_start && (divReadyAt != 0) && (divCnt + 1 == divReadyAt);
    assign bus.div_result = divRes;

    typedef struct {
        op_code_t    opCode;
        logic [31:0] src1;
        logic [31:0] src2;
        int          readyAt;
        logic [63:0] divRes;
        logic [63:0] expHl;
        int          expStall;
        int          expStart;
        logic        expMulSigned;
        logic        expDivSigned;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [199:0] allOuts();
        return {bus.mul_signed, bus.mul_ina, bus.mul_inb, bus.div_start, bus.div_signed,
                bus.div_opdata1, bus.div_opdata2, bus.div_annul, bus.stallreq, bus.hl_we,
                bus.hl_wdata, bus.busy, bus.timeout_err};
    endfunction

    task automatic checkOutput(input string name, input logic [199:0] actual, input logic [199:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic opValid, input op_code_t opCode, input logic [31:0] src1,
                                 input logic [31:0] src2, input logic flushIn, input logic exAdvance);
        bus.op_valid   = opValid;
        bus.op_code    = opCode;
        bus.op_src1    = src1;
        bus.op_src2    = src2;
        bus.flush      = flushIn;
        bus.ex_advance = exAdvance;
    endtask

    // Issue one table entry, watch it to DONE, then release it with ex_advance.
    task automatic runVector(input int idx);
        vec_t v;
        int   stallCnt;
        int   startCnt;
        int   badCycles;
        bit   done;
        v = vecs[idx];
        stallCnt = 0; startCnt = 0; badCycles = 0; done = 0;
        @(negedge clk);
        applyStimulus(1'b1, v.opCode, v.src1, v.src2, 1'b0, 1'b0);
        divReadyAt = v.readyAt;
        divRes     = v.divRes;
        for (int c = 0; c < 200 && !done; c++) begin
            #1;
            if (bus.stallreq) stallCnt++;
            if (bus.div_start) begin
                startCnt++;
                if (bus.div_opdata1 != v.src1 || bus.div_opdata2 != v.src2 ||
                    bus.div_signed != v.expDivSigned) badCycles++;
            end else if (bus.div_opdata1 != 0 || bus.div_opdata2 != 0 || bus.div_signed) begin
                badCycles++;
            end
            if (bus.busy && !bus.div_start && !bus.hl_we) begin
                if (bus.mul_ina != v.src1 || bus.mul_inb != v.src2 ||
                    bus.mul_signed != v.expMulSigned) badCycles++;
            end else if (bus.mul_ina != 0 || bus.mul_inb != 0 || bus.mul_signed) begin
                badCycles++;
            end
            if (bus.hl_we) begin
                done = 1;
                checkOutput($sformatf("vec%0d_hl_wdata", idx), 200'(bus.hl_wdata), 200'(v.expHl));
                checkOutput($sformatf("vec%0d_stall_cycles", idx), 200'(stallCnt), 200'(v.expStall));
                checkOutput($sformatf("vec%0d_start_cycles", idx), 200'(startCnt), 200'(v.expStart));
                checkOutput($sformatf("vec%0d_operands", idx), 200'(badCycles), 200'(0));
            end else begin
                @(negedge clk);
            end
        end
        if (!done) checkOutput($sformatf("vec%0d_reach_done", idx), 200'(0), 200'(1));
        applyStimulus(1'b0, OP_MULT, '0, '0, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, OP_MULT, '0, '0, 1'b0, 1'b0);
        #1;
        checkOutput($sformatf("vec%0d_released", idx), 200'({bus.busy, bus.hl_we, bus.stallreq}), 200'(0));
    endtask

    initial begin
        int   bad;
        bit   seen;
        logic [63:0] holdExp;

        vecs[0] = '{OP_MULT,  32'hFFFF_FFFF, 32'd2,          0,  64'd0,
                    64'hFFFF_FFFE_FFFF_FFFF, 3,  0,  1'b1, 1'b0};
        vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'd2,          0,  64'd0,
                    64'hFFFF_FFFE_0000_0001, 3,  0,  1'b0, 1'b0};
        vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,          34, 64'hFFFF_FFFF_FFFF_FFFD,
                    64'hFFFF_FFFD_FFFF_FFFF, 35, 34, 1'b0, 1'b1};
        vecs[3] = '{OP_DIVU,  32'd5,         32'd0,          0,  64'd0,
                    64'hFFFF_FFFF_0000_0005, 1,  0,  1'b0, 1'b0};
        vecs[4] = '{OP_MULT,  32'd3,         32'hFFFF_FFFC,  0,  64'd0,
                    64'hFFFF_FFF4_FFFF_FFFF, 3,  0,  1'b1, 1'b0};
        vecs[5] = '{OP_DIVU,  32'd100,       32'd7,          5,  64'h0000_0002_0000_000E,
                    64'h0000_000E_0000_0002, 6,  5,  1'b0, 1'b0};
        vecs[6] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  3,  64'h0000_0000_8000_0000,
                    64'h8000_0000_0000_0000, 4,  3,  1'b0, 1'b1};

        applyStimulus(1'b0, OP_MULT, '0, '0, 1'b0, 1'b0);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_outputs_in_reset", allOuts(), '0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checkOutput("reset_outputs_idle", allOuts(), '0);

        for (int i = 0; i < 7; i++) runVector(i);

        // Flush while idle: stall suppressed, nothing starts.
        @(negedge clk);
        applyStimulus(1'b1, OP_MULT, 32'd1, 32'd1, 1'b1, 1'b0);
        #1;
        checkOutput("idle_flush_stall", 200'(bus.stallreq), 200'(0));
        @(negedge clk);
        applyStimulus(1'b0, OP_MULT, '0, '0, 1'b0, 1'b0);
        #1;
        checkOutput("idle_flush_busy", 200'(bus.busy), 200'(0));

        // Flush on the 10th DIV cycle.
        @(negedge clk);
        applyStimulus(1'b1, OP_DIV, 32'd20, 32'd3, 1'b0, 1'b0);
        divReadyAt = 0;
        bad = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            #1;
            if (!bus.div_start || bus.div_annul || !bus.stallreq) bad++;
        end
        checkOutput("flush_div_running", 200'(bad), 200'(0));
        @(negedge clk);
        applyStimulus(1'b0, OP_DIV, 32'd20, 32'd3, 1'b1, 1'b0);
        #1;
        checkOutput("flush_div_cycle", 200'({bus.div_annul, bus.stallreq, bus.hl_we}), 200'(3'b100));
        @(negedge clk);
        applyStimulus(1'b0, OP_MULT, '0, '0, 1'b0, 1'b0);
        #1;
        checkOutput("flush_div_idle", 200'({bus.busy, bus.div_start}), 200'(0));
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            seen |= bus.hl_we;
        end
        checkOutput("flush_div_no_hl_we", 200'(seen), 200'(0));

        // Divider never ready: watchdog fires on the 64th DIV cycle.
        @(negedge clk);
        applyStimulus(1'b1, OP_DIV, 32'd20, 32'd3, 1'b0, 1'b0);
        bad = 0;
        for (int i = 1; i <= 63; i++) begin
            @(negedge clk);
            #1;
            if (bus.timeout_err || bus.div_annul || !bus.div_start) bad++;
        end
        checkOutput("watchdog_quiet", 200'(bad), 200'(0));
        @(negedge clk);
        #1;
        checkOutput("watchdog_pulse", 200'({bus.timeout_err, bus.div_annul}), 200'(2'b11));
        @(negedge clk);
        #1;
        checkOutput("watchdog_done", 200'({bus.hl_we, bus.timeout_err, bus.div_start}), 200'(3'b100));
        checkOutput("watchdog_hl_wdata", 200'(bus.hl_wdata), 200'(0));
        applyStimulus(1'b0, OP_MULT, '0, '0, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, OP_MULT, '0, '0, 1'b0, 1'b0);

        // DONE held for 5 cycles with op_valid still high: no restart.
        @(negedge clk);
        applyStimulus(1'b1, OP_MULT, 32'd6, 32'd7, 1'b0, 1'b0);
        holdExp = 64'h0000_002A_0000_0000;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            if (bus.hl_we) seen = 1;
            else @(negedge clk);
        end
        checkOutput("hold_reach_done", 200'(seen), 200'(1));
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (!bus.hl_we || bus.hl_wdata != holdExp || bus.div_start || bus.mul_ina != 0 ||
                bus.stallreq) bad++;
        end
        checkOutput("hold_done_stable", 200'(bad), 200'(0));
        applyStimulus(1'b0, OP_MULT, '0, '0, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, OP_MULT, '0, '0, 1'b0, 1'b0);
        #1;
        checkOutput("hold_released", 200'(bus.busy), 200'(0));

        // Reset on the 3rd DIV cycle drops the op without annulling.
        @(negedge clk);
        applyStimulus(1'b1, OP_DIVU, 32'd9, 32'd4, 1'b0, 1'b0);
        divReadyAt = 0;
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        applyStimulus(1'b0, OP_MULT, '0, '0, 1'b0, 1'b0);
        #1;
        checkOutput("reset_mid_div_no_annul", 200'({bus.div_start, bus.div_annul}), 200'(2'b10));
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checkOutput("reset_mid_div_outputs", allOuts(), '0);

        runVector(0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
